// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE -> PLAY -> FINISH flow with single-cycle game tick, BCD countdown timer,
// BCD score fed from a pending-points accumulator, and the registered Row1 status line.
module game_flow_ctrl #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int GAME_TICKS = 15,
  parameter int PEND_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        hit_valid,
  input  logic [2:0]  hit_count,
  output logic        game_en,
  output logic        game_tick,
  output logic        clear_pulse,
  output logic [1:0]  state,
  output logic        finished,
  output logic [39:0] Row1
);
  // state  | meaning
  // IDLE   | after reset, waiting for the first start press
  // PLAY   | game running: ticks, countdown and hits active
  // FINISH | timer at 00, pending points still drain, restart allowed
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, FINISH = 2'b10} state_t;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam int SUM_W = PEND_W + 4;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [3:0] TICKS_HI = 4'(GAME_TICKS / 10);
  localparam logic [3:0] TICKS_LO = 4'(GAME_TICKS % 10);
  localparam logic [4:0] DARK = 5'd31;

  state_t state_q, state_d;
  logic en_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] tmr_hi_q, tmr_hi_d, tmr_lo_q, tmr_lo_d;
  logic [3:0][3:0] score_q, score_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [SUM_W-1:0] pend_sum;
  logic clear_q, clear_d;
  logic [39:0] row_q, row_d;
  logic en_rise, start, drain, hit_ok, carry;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmr_hi_d = tmr_hi_q;
    tmr_lo_d = tmr_lo_q;
    score_d  = score_q;
    pend_d   = pend_q;
    clear_d  = 1'b0;
    carry    = 1'b1;

    en_rise   = en & ~en_q;
    start     = en_rise && (state_q != PLAY);
    drain     = (pend_q != '0);
    hit_ok    = hit_valid && (state_q == PLAY);
    game_en   = (state_q == PLAY);
    game_tick = (state_q == PLAY) && (cnt_q == CNT_LAST);
    finished  = (state_q == FINISH);
    state     = state_q;

    pend_sum = SUM_W'(pend_q) + (hit_ok ? SUM_W'(hit_count) : '0) - (drain ? SUM_W'(1) : '0);

    if (start) begin
      state_d  = PLAY;
      cnt_d    = '0;
      tmr_hi_d = TICKS_HI;
      tmr_lo_d = TICKS_LO;
      score_d  = '0;
      pend_d   = '0;
      clear_d  = 1'b1;
    end else begin
      pend_d = (pend_sum > SUM_W'(PEND_MAX)) ? PEND_MAX : pend_sum[PEND_W-1:0];
      // At 9999 the drained point is simply discarded
      if (drain && (score_q != 16'h9999)) begin
        for (int i = 0; i < 4; i++) begin
          if (carry) begin
            if (score_q[i] == 4'd9) begin
              score_d[i] = 4'd0;
            end else begin
              score_d[i] = score_q[i] + 4'd1;
              carry      = 1'b0;
            end
          end
        end
      end
      if (state_q == PLAY) begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        if (game_tick) begin
          if (tmr_lo_q == 4'd0) begin
            tmr_lo_d = 4'd9;
            tmr_hi_d = tmr_hi_q - 4'd1;
          end else begin
            tmr_lo_d = tmr_lo_q - 4'd1;
          end
          if ((tmr_hi_q == 4'd0) && (tmr_lo_q == 4'd1)) state_d = FINISH;
        end
      end
    end

    if (state_q == IDLE)
      row_d = {8{DARK}};
    else
      row_d = {1'b0, tmr_hi_q, 1'b0, tmr_lo_q, DARK, DARK,
               1'b0, score_q[3], 1'b0, score_q[2], 1'b0, score_q[1], 1'b0, score_q[0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      cnt_q    <= '0;
      tmr_hi_q <= TICKS_HI;
      tmr_lo_q <= TICKS_LO;
      score_q  <= '0;
      pend_q   <= '0;
      clear_q  <= 1'b0;
      row_q    <= {8{DARK}};
    end else begin
      en_q     <= en;
      cnt_q    <= cnt_d;
      tmr_hi_q <= tmr_hi_d;
      tmr_lo_q <= tmr_lo_d;
      score_q  <= score_d;
      pend_q   <= pend_d;
      clear_q  <= clear_d;
      row_q    <= row_d;
    end
  end

  assign clear_pulse = clear_q;
  assign Row1        = row_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomized bench for game_flow_ctrl; an integer-level game model predicts every output each cycle.
module tb_game_flow_ctrl;
  localparam int TICK_DIV   = 900;
  localparam int GAME_TICKS = 12;
  localparam int PEND_W     = 8;
  localparam int PEND_MAX   = (1 << PEND_W) - 1;
  localparam int GAME_LEN   = TICK_DIV * GAME_TICKS;

  logic clk = 1'b0;
  logic rst, en, hit_valid;
  logic [2:0] hit_count;
  logic game_en, game_tick, clear_pulse, finished;
  logic [1:0] state;
  logic [39:0] Row1;

  game_flow_ctrl #(.TICK_DIV(TICK_DIV), .GAME_TICKS(GAME_TICKS), .PEND_W(PEND_W)) dut (
    .clk(clk), .rst(rst), .en(en), .hit_valid(hit_valid), .hit_count(hit_count),
    .game_en(game_en), .game_tick(game_tick), .clear_pulse(clear_pulse),
    .state(state), .finished(finished), .Row1(Row1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 play, 2 finish; timer counts remaining ticks, score is a plain integer
  int m_state, m_timer, m_score, m_pending, m_cnt;
  bit m_clear, m_en_q;
  logic [39:0] m_row;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] row_of(input int st, input int tmr, input int sc);
    if (st == 0) return {8{5'd31}};
    return {5'(tmr / 10), 5'(tmr % 10), 5'd31, 5'd31,
            5'(sc / 1000), 5'((sc / 100) % 10), 5'((sc / 10) % 10), 5'(sc % 10)};
  endfunction

  function automatic void model_reset();
    m_state = 0; m_timer = GAME_TICKS; m_score = 0; m_pending = 0; m_cnt = 0;
    m_clear = 1'b0; m_en_q = 1'b0; m_row = {8{5'd31}};
  endfunction

  function automatic void model_step(input bit r, input bit e, input bit hv, input int hc);
    bit rise, tick;
    if (r) begin
      model_reset();
      return;
    end
    rise   = e && !m_en_q;
    m_en_q = e;
    tick   = (m_state == 1) && (m_cnt == TICK_DIV - 1);
    m_row  = row_of(m_state, m_timer, m_score);
    m_clear = 1'b0;
    if (m_state != 1 && rise) begin
      m_state = 1; m_score = 0; m_pending = 0; m_cnt = 0; m_timer = GAME_TICKS; m_clear = 1'b1;
      return;
    end
    if (m_pending > 0) begin
      m_pending--;
      if (m_score < 9999) m_score++;
    end
    if (m_state == 1) begin
      if (hv) m_pending = (m_pending + hc > PEND_MAX) ? PEND_MAX : m_pending + hc;
      m_cnt = (m_cnt + 1) % TICK_DIV;
      if (tick) begin
        m_timer--;
        if (m_timer == 0) m_state = 2;
      end
    end
  endfunction

  task automatic check_outputs();
    check("state", 64'(state), 64'(m_state));
    check("game_en", 64'(game_en), 64'(m_state == 1));
    check("game_tick", 64'(game_tick), 64'((m_state == 1) && (m_cnt == TICK_DIV - 1)));
    check("finished", 64'(finished), 64'(m_state == 2));
    check("clear_pulse", 64'(clear_pulse), 64'(m_clear));
    check("row1", 64'(Row1), 64'(m_row));
  endtask

  task automatic cyc(input bit r, input bit e, input bit hv, input int hc);
    @(negedge clk);
    check_outputs();
    rst = r; en = e; hit_valid = hv; hit_count = 3'(hc);
    model_step(r, e, hv, hc);
  endtask

  // en toggles only during PLAY so FINISH restarts happen only where the sequence asks for them
  task automatic run(input int n, input int hit_pct, input int en_pct, input int hc_min);
    bit e;
    e = en;
    for (int i = 0; i < n; i++) begin
      bit hv;
      int hc;
      if (m_state == 1 && $urandom_range(0, 99) < en_pct) e = ~e;
      hv = ($urandom_range(0, 99) < hit_pct);
      hc = $urandom_range(hc_min, 7);
      if (m_state == 1 && m_cnt == TICK_DIV - 1 && m_timer == 1) begin
        hv = 1'b1;
        hc = 7;
      end
      cyc(1'b0, e, hv, hc);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; hit_valid = 1'b0; hit_count = 3'd0;
    repeat (2) @(posedge clk);
    model_reset();
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 7));

    cyc(1'b0, 1'b1, 1'b0, 0);
    run(GAME_LEN + 300, 40, 3, 0);

    cyc(1'b0, 1'b0, 1'b1, 3);
    cyc(1'b0, 1'b1, 1'b1, 4);
    run(GAME_LEN + 300, 100, 0, 5);

    cyc(1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0);
    run(60, 60, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, 7);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
    cyc(1'b0, 1'b1, 1'b0, 0);
    run(3 * TICK_DIV, 50, 5, 0);
    cyc(1'b0, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
